// File: rtl/tick_bcd_pkg.sv
// Shared constants and types for the tick-driven BCD counter and display scanner.
package tick_bcd_pkg;

  localparam int NUM_DIGITS       = 4;
  localparam int DEFAULT_SCAN_DIV = 100000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [1:0] digit_idx_t;

  // Clamp an out-of-range BCD nibble to 9.
  function automatic logic [3:0] sat_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/tick_bcd_display_bcd_to_7seg.sv
// Combinational BCD digit to active-low seven-segment decoder, [0]=a .. [6]=g.
module bcd_to_7seg
  import tick_bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Decode one digit; non-decimal codes show nothing.
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/tick_bcd_display.sv
// Four-digit BCD up/down counter stepped by rising edges of tick_in, with a
// multiplexed active-low seven-segment display scanner.
module tick_bcd_display
  import tick_bcd_pkg::*;
#(
  parameter int SCAN_DIV      = DEFAULT_SCAN_DIV,
  parameter int LEADING_BLANK = 0
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        tick_in,
  input  logic        count_en,
  input  logic        up_down,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [15:0] bcd_value,
  output logic        rollover,
  output logic [3:0]  anode,
  output logic [6:0]  segments
);

  localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);

  logic               tick_d;
  logic               step;
  logic [15:0]        count_next;
  logic               wrap;
  logic [15:0]        load_sat;
  logic [PRESC_W-1:0] presc;
  digit_idx_t         digit_idx;
  logic [3:0]         digit_sel;
  logic [3:0]         blank_mask;
  logic               blank_sel;
  logic [6:0]         seg_dec;

  // tick_in is already in the clk_in domain, so a single register gives the edge.
  assign step = tick_in & ~tick_d & count_en;

  // Edge-detect history; reset to 1 so a high tick_in at release is not a step.
  always_ff @(posedge clk_in) begin
    if (reset) tick_d <= 1'b1;
    else       tick_d <= tick_in;
  end

  // Ripple BCD increment/decrement; wrap is the carry/borrow out of the top digit.
  always_comb begin
    logic       carry;
    logic [3:0] digit;
    count_next = bcd_value;
    carry      = 1'b1;
    digit      = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit = bcd_value[i*4 +: 4];
      if (carry) begin
        if (up_down) begin
          if (digit >= 4'd9) begin
            count_next[i*4 +: 4] = 4'd0;
          end else begin
            count_next[i*4 +: 4] = digit + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            count_next[i*4 +: 4] = 4'd9;
          end else begin
            count_next[i*4 +: 4] = digit - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    wrap = carry;
  end

  // Load value with every illegal nibble clamped to 9.
  always_comb begin
    load_sat = 16'h0000;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      load_sat[i*4 +: 4] = sat_digit(load_value[i*4 +: 4]);
    end
  end

  // Count register: reset beats load, load beats step; rollover pulses on a stepped wrap.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      bcd_value <= 16'h0000;
      rollover  <= 1'b0;
    end else begin
      rollover <= 1'b0;
      if (load) begin
        bcd_value <= load_sat;
      end else if (step) begin
        bcd_value <= count_next;
        rollover  <= wrap;
      end
    end
  end

  // Scan prescaler and digit index; the index advances when the prescaler wraps.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      presc     <= '0;
      digit_idx <= digit_idx_t'(0);
    end else if (presc == PRESC_LAST) begin
      presc     <= '0;
      digit_idx <= digit_idx + digit_idx_t'(1);
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

  // Leading-zero mask: a digit is blankable when it and everything above it is 0.
  always_comb begin
    blank_mask    = 4'b0000;
    blank_mask[3] = (bcd_value[15:12] == 4'd0);
    blank_mask[2] = blank_mask[3] && (bcd_value[11:8] == 4'd0);
    blank_mask[1] = blank_mask[2] && (bcd_value[7:4] == 4'd0);
    blank_mask[0] = 1'b0;
    if (LEADING_BLANK == 0) blank_mask = 4'b0000;
  end

  // Select the digit and blank flag for the current scan position.
  always_comb begin
    digit_sel = bcd_value[3:0];
    blank_sel = blank_mask[0];
    case (digit_idx)
      2'd0: begin digit_sel = bcd_value[3:0];   blank_sel = blank_mask[0]; end
      2'd1: begin digit_sel = bcd_value[7:4];   blank_sel = blank_mask[1]; end
      2'd2: begin digit_sel = bcd_value[11:8];  blank_sel = blank_mask[2]; end
      2'd3: begin digit_sel = bcd_value[15:12]; blank_sel = blank_mask[3]; end
      default: begin digit_sel = bcd_value[3:0]; blank_sel = 1'b0; end
    endcase
  end

  bcd_to_7seg u_dec (
    .digit (digit_sel),
    .seg   (seg_dec)
  );

  // Anode and segments come from the same index in one register stage, so they always agree.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      anode    <= 4'b1110;
      segments <= 7'h40;
    end else begin
      anode    <= ~(4'b0001 << digit_idx);
      segments <= blank_sel ? SEG_BLANK : seg_dec;
    end
  end

endmodule

// File: tb/tb_tick_bcd_display.sv
// Directed bench for tick_bcd_display with a fast scan rate and leading-zero blanking.
module tb_tick_bcd_display;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        tick_in;
  logic        count_en;
  logic        up_down;
  logic        load;
  logic [15:0] load_value;
  logic [15:0] bcd_value;
  logic        rollover;
  logic [3:0]  anode;
  logic [6:0]  segments;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];

  tick_bcd_display #(
    .SCAN_DIV      (4),
    .LEADING_BLANK (1)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .tick_in    (tick_in),
    .count_en   (count_en),
    .up_down    (up_down),
    .load       (load),
    .load_value (load_value),
    .bcd_value  (bcd_value),
    .rollover   (rollover),
    .anode      (anode),
    .segments   (segments)
  );

  // Clock
  always #5 clk_in = ~clk_in;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic cycle(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Land on the first cycle of anode=1110 (bounded waits).
  task automatic sync_scan(input string tag);
    int  n;
    logic found;
    n = 0;
    while (anode === 4'b1110 && n < 40) begin cycle(); n++; end
    n = 0;
    while (anode !== 4'b1110 && n < 40) begin cycle(); n++; end
    found = (anode === 4'b1110);
    check(tag, {15'd0, found}, 16'd1);
  endtask

  initial begin
    logic [15:0] exp_bcd;
    logic [3:0]  exp_an[4];
    logic [6:0]  exp_seg[4];

    // Reset held with tick_in high
    reset = 1'b1; tick_in = 1'b1; count_en = 1'b1; up_down = 1'b1;
    load = 1'b0; load_value = 16'h0000;
    cycle(3);
    check("reset_bcd",      bcd_value,          16'h0000);
    check("reset_rollover", {15'd0, rollover},  16'h0000);
    check("reset_anode",    {12'd0, anode},     16'h000E);
    check("reset_segments", {9'd0, segments},   16'h0040);

    // Release with tick_in still high: no step until a fresh rising edge
    reset = 1'b0;
    cycle(3);
    check("release_no_step", bcd_value, 16'h0000);
    tick_in = 1'b0; cycle();
    check("tick_low_hold", bcd_value, 16'h0000);
    tick_in = 1'b1; cycle();
    check("first_edge", bcd_value, 16'h0001);

    // Up count across a decade boundary from 0998
    tick_in = 1'b0; load = 1'b1; load_value = 16'h0998; cycle();
    load = 1'b0;
    check("load_0998", bcd_value, 16'h0998);
    exp_q.push_back(16'h0999);
    exp_q.push_back(16'h1000);
    exp_q.push_back(16'h1001);
    while (exp_q.size() > 0) begin
      exp_bcd = exp_q.pop_front();
      tick_in = 1'b1; cycle();
      check("up_count", bcd_value, exp_bcd);
      check("up_no_rollover_a", {15'd0, rollover}, 16'h0000);
      tick_in = 1'b0; cycle();
      check("up_no_rollover_b", {15'd0, rollover}, 16'h0000);
    end

    // 9999 -> 0000 with a single-cycle rollover
    load = 1'b1; load_value = 16'h9999; cycle();
    load = 1'b0;
    tick_in = 1'b1; cycle();
    check("wrap_up_bcd",  bcd_value,         16'h0000);
    check("wrap_up_roll", {15'd0, rollover}, 16'h0001);
    cycle();
    check("wrap_up_roll_clear", {15'd0, rollover}, 16'h0000);

    // Direction change alone does not move the count
    tick_in = 1'b0; up_down = 1'b0; cycle();
    check("dir_change_hold", bcd_value, 16'h0000);

    // 0000 -> 9999 with a single-cycle rollover
    tick_in = 1'b1; cycle();
    check("wrap_dn_bcd",  bcd_value,         16'h9999);
    check("wrap_dn_roll", {15'd0, rollover}, 16'h0001);
    cycle();
    check("wrap_dn_roll_clear", {15'd0, rollover}, 16'h0000);
    check("wrap_dn_hold",       bcd_value,         16'h9999);

    // Down count with a borrow chain
    tick_in = 1'b0; load = 1'b1; load_value = 16'h1000; cycle();
    load = 1'b0;
    tick_in = 1'b1; cycle();
    check("down_borrow", bcd_value, 16'h0999);

    // Load with clamping beats a simultaneous step
    tick_in = 1'b0; up_down = 1'b1; cycle();
    tick_in = 1'b1; load = 1'b1; load_value = 16'h1A3F; cycle();
    check("load_priority_bcd",  bcd_value,         16'h1939);
    check("load_priority_roll", {15'd0, rollover}, 16'h0000);
    load = 1'b0; cycle();
    check("load_priority_hold", bcd_value, 16'h1939);

    // count_en low holds the count while tick_d keeps tracking
    tick_in = 1'b0; cycle();
    count_en = 1'b0; tick_in = 1'b1; cycle();
    check("count_en_off", bcd_value, 16'h1939);
    count_en = 1'b1; cycle();
    check("count_en_on_no_stale_edge", bcd_value, 16'h1939);

    // Reset overrides load and step in the same cycle
    tick_in = 1'b0; cycle();
    reset = 1'b1; tick_in = 1'b1; load = 1'b1; load_value = 16'h5555; cycle();
    check("reset_override", bcd_value, 16'h0000);
    reset = 1'b0; load = 1'b0; cycle();
    check("reset_override_after", bcd_value, 16'h0000);

    // Scan of 1234: each position held 4 cycles
    load = 1'b1; load_value = 16'h1234; cycle();
    load = 1'b0;
    exp_an[0] = 4'b1110; exp_seg[0] = 7'h19;
    exp_an[1] = 4'b1101; exp_seg[1] = 7'h30;
    exp_an[2] = 4'b1011; exp_seg[2] = 7'h24;
    exp_an[3] = 4'b0111; exp_seg[3] = 7'h79;
    sync_scan("scan_sync_1234");
    for (int k = 0; k < 4; k++) begin
      check("scan_anode_first", {12'd0, anode},    {12'd0, exp_an[k]});
      check("scan_seg_first",   {9'd0, segments},  {9'd0, exp_seg[k]});
      cycle(3);
      check("scan_anode_last",  {12'd0, anode},    {12'd0, exp_an[k]});
      check("scan_seg_last",    {9'd0, segments},  {9'd0, exp_seg[k]});
      cycle();
    end

    // Leading-zero blanking of 0007
    load = 1'b1; load_value = 16'h0007; cycle();
    load = 1'b0;
    exp_seg[0] = 7'h78; exp_seg[1] = 7'h7F; exp_seg[2] = 7'h7F; exp_seg[3] = 7'h7F;
    sync_scan("scan_sync_0007");
    for (int k = 0; k < 4; k++) begin
      check("blank_anode", {12'd0, anode},   {12'd0, exp_an[k]});
      check("blank_seg",   {9'd0, segments}, {9'd0, exp_seg[k]});
      cycle(4);
    end

    // Interior zero is not blanked: 0307
    load = 1'b1; load_value = 16'h0307; cycle();
    load = 1'b0;
    exp_seg[0] = 7'h78; exp_seg[1] = 7'h40; exp_seg[2] = 7'h30; exp_seg[3] = 7'h7F;
    sync_scan("scan_sync_0307");
    for (int k = 0; k < 4; k++) begin
      check("interior_zero_seg", {9'd0, segments}, {9'd0, exp_seg[k]});
      cycle(4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
